// File: rtl/service_counter_if.sv
// Dispatcher <-> service counter link: load strobe in, status and display out.
interface service_counter_if;
  logic       ld;
  logic [3:0] dn;
  logic [3:0] dt;
  logic       busy;
  logic [3:0] cur_num;
  logic [3:0] remain;
  logic       done;
  logic [7:0] served_cnt;

  modport master (
    output ld, dn, dt,
    input  busy, cur_num, remain, done, served_cnt
  );

  modport slave (
    input  ld, dn, dt,
    output busy, cur_num, remain, done, served_cnt
  );
endinterface

// File: rtl/service_counter.sv
// Teller window: captures a customer on load, counts service time down in
// prescaled units, pulses done and tallies completed customers.
module service_counter #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input logic               clk,
  input logic               rst_n,
  service_counter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SERVE, DONE} state_e;

  localparam logic [25:0] PRE_LAST = 26'(TICK_DIV - 1);

  state_e      state_q, state_d;
  logic [25:0] pre_q, pre_d;
  logic [3:0]  num_q, num_d;
  logic [3:0]  rem_q, rem_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        tick;

  assign tick = (pre_q == PRE_LAST);

  always_comb begin
    state_d = state_q;
    pre_d   = '0;
    num_d   = num_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.ld) begin
          num_d   = bus.dn;
          rem_d   = (bus.dt == 4'd0) ? 4'd1 : bus.dt;
          state_d = SERVE;
        end
      end
      SERVE: begin
        pre_d = tick ? 26'd0 : pre_q + 26'd1;
        if (tick) begin
          if (rem_q > 4'd1) begin
            rem_d = rem_q - 4'd1;
          end else begin
            rem_d   = 4'd0;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (cnt_q != 8'hff) cnt_d = cnt_q + 8'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Status flags are registered copies of the next state.
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pre_q   <= '0;
      num_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      num_q   <= num_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.cur_num    = num_q;
  assign bus.remain     = rem_q;
  assign bus.served_cnt = cnt_q;

endmodule

// File: tb/tb_service_counter.sv
// Bench for service_counter with TICK_DIV=4: vector table plus
// reset-mid-service and back-to-back/saturation sequences.
module tb_service_counter;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [3:0] num;
    logic [3:0] rem;
    logic [7:0] cnt;
  } out_t;

  typedef struct packed {
    logic       ld;
    logic [3:0] dn;
    logic [3:0] dt;
    out_t       exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  service_counter_if bus();

  service_counter #(.TICK_DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  vec_t tbl[$];
  out_t exp_q[$];

  function automatic out_t mk(logic b, logic d, logic [3:0] n,
                              logic [3:0] r, logic [7:0] c);
    out_t o;
    o.busy = b;
    o.done = d;
    o.num  = n;
    o.rem  = r;
    o.cnt  = c;
    return o;
  endfunction

  function automatic out_t sample();
    return mk(bus.busy, bus.done, bus.cur_num, bus.remain, bus.served_cnt);
  endfunction

  task automatic add(logic ld, logic [3:0] dn, logic [3:0] dt, logic b,
                     logic d, logic [3:0] n, logic [3:0] r, logic [7:0] c);
    vec_t v;
    v.ld  = ld;
    v.dn  = dn;
    v.dt  = dt;
    v.exp = mk(b, d, n, r, c);
    tbl.push_back(v);
  endtask

  task automatic check(string name, out_t got, out_t exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got busy=%b done=%b num=%0d rem=%0d cnt=%0d, want busy=%b done=%b num=%0d rem=%0d cnt=%0d",
               name, got.busy, got.done, got.num, got.rem, got.cnt,
               exp.busy, exp.done, exp.num, exp.rem, exp.cnt);
    end
  endtask

  task automatic check_int(string name, int got, int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   lat;
    logic [7:0] cnt_exp;
    out_t got;

    bus.ld = 1'b0;
    bus.dn = '0;
    bus.dt = '0;

    // Rows: inputs before an edge, outputs expected after it.
    add(0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 11, 2, 1, 0, 11, 2, 0);
    add(0, 0, 0, 1, 0, 11, 2, 0);
    add(1, 5, 9, 1, 0, 11, 2, 0);
    add(0, 0, 0, 1, 0, 11, 2, 0);
    add(0, 0, 0, 1, 0, 11, 1, 0);
    add(0, 0, 0, 1, 0, 11, 1, 0);
    add(1, 5, 9, 1, 0, 11, 1, 0);
    add(0, 0, 0, 1, 0, 11, 1, 0);
    add(0, 0, 0, 1, 1, 11, 0, 0);
    add(0, 0, 0, 0, 0, 11, 0, 1);
    add(0, 0, 0, 0, 0, 11, 0, 1);
    add(1, 3, 0, 1, 0, 3, 1, 1);
    add(0, 0, 0, 1, 0, 3, 1, 1);
    add(0, 0, 0, 1, 0, 3, 1, 1);
    add(0, 0, 0, 1, 0, 3, 1, 1);
    add(0, 0, 0, 1, 1, 3, 0, 1);
    add(1, 7, 5, 0, 0, 3, 0, 2);
    add(0, 0, 0, 0, 0, 3, 0, 2);

    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", sample(), mk(0, 0, 0, 0, 0));
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      bus.ld = tbl[i].ld;
      bus.dn = tbl[i].dn;
      bus.dt = tbl[i].dt;
      exp_q.push_back(tbl[i].exp);
      step();
      check($sformatf("vec%0d", i), sample(), exp_q.pop_front());
    end
    bus.ld = 1'b0;

    // Asynchronous reset in the middle of a service.
    bus.ld = 1'b1;
    bus.dn = 4'd12;
    bus.dt = 4'd4;
    step();
    bus.ld = 1'b0;
    check("rst_mid_load", sample(), mk(1, 0, 12, 4, 2));
    repeat (6) step();
    check("rst_mid_e6", sample(), mk(1, 0, 12, 3, 2));
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_async", sample(), mk(0, 0, 0, 0, 0));
    repeat (2) step();
    check("rst_mid_held", sample(), mk(0, 0, 0, 0, 0));
    rst_n = 1'b1;
    lat = 0;
    repeat (12) begin
      step();
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) lat++;
    end
    check_int("rst_mid_no_done", lat, 0);
    check("rst_mid_after", sample(), mk(0, 0, 0, 0, 0));

    // Back-to-back services with dt=1 up to counter saturation.
    cnt_exp = 8'd0;
    for (int i = 0; i < 260; i++) begin
      bus.ld = 1'b1;
      bus.dn = 4'(i);
      bus.dt = 4'd1;
      exp_q.push_back(mk(1, 0, 4'(i), 1, cnt_exp));
      step();
      bus.ld = 1'b0;
      check($sformatf("b2b_load%0d", i), sample(), exp_q.pop_front());
      lat = 0;
      do begin
        step();
        lat++;
      end while (bus.done !== 1'b1 && lat < 20);
      check_int($sformatf("b2b_done_lat%0d", i), lat, 4);
      if (lat >= 20) break;
      step();
      if (cnt_exp != 8'hff) cnt_exp = cnt_exp + 8'd1;
      got = sample();
      check($sformatf("b2b_idle%0d", i), got, mk(0, 0, 4'(i), 0, cnt_exp));
    end
    check_int("sat_final", int'(bus.served_cnt), 255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
